// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared constants for the two-requester memory arbiter.
//                Port 0 is instruction fetch, port 1 is data load/store.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Default memory geometry of the accumulator datapath
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 10;

    // Requester indices, usable directly as bit positions in req/gnt vectors
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Kind of access a requester presents
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Index of the granted port; only meaningful when exactly one gnt is high
    function automatic logic granted_port(input logic [1:0] gnt);
        return gnt[PORT_DATA];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundles both requester handshakes and the memory-side bus.
//                slave  = the arbiter's view, master = requesters + memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = mem_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_arbiter_pkg::ADDR_WIDTH
);

    // Requester 0 (instruction fetch)
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    // Requester 1 (data load/store)
    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    // Memory side
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_q,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_addr, mem_data, mem_we
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_q,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_addr, mem_data, mem_we
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant logic. Grant is combinational from
//                req and the last-grant pointer; the pointer moves only when a
//                grant is actually taken (accept).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] req,
    input  wire logic       accept,
    output logic      [1:0] gnt
);

    // Port that won the most recent accepted transfer; reset to the data port
    // so that the fetch port wins the first tie.
    logic r_last;

    // Grant: a lone requester wins outright, a tie goes to the port not last
    // served; nothing is granted while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_last == PORT_DATA) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer update on each accepted transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= PORT_DATA;
        end else if (accept) begin
            r_last <= granted_port(gnt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous memory (registered read)
//                between instruction fetch (port 0) and data (port 1).
//                Round-robin grant, 1-cycle read response routed back to the
//                port that issued it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
)(
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);

    import mem_arbiter_pkg::*;

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_accept;
    logic                  w_sel;
    logic                  w_sel_we;
    logic                  w_rd_accept;
    logic                  w_rvalid0;
    logic                  w_rvalid1;

    logic                  r_rd_pend;
    logic                  r_rd_owner;
    logic [DATA_WIDTH-1:0] r_hold0;
    logic [DATA_WIDTH-1:0] r_hold1;

    assign w_req = {bus.req1, bus.req0};

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    (w_req),
        .accept (w_accept),
        .gnt    (w_gnt)
    );

    // A transfer happens whenever a granted port is requesting
    assign w_accept = |(w_req & w_gnt);

    assign bus.gnt0 = w_gnt[PORT_FETCH];
    assign bus.gnt1 = w_gnt[PORT_DATA];

    // With no grant the select stays on port 0, giving a deterministic bus
    assign w_sel    = granted_port(w_gnt);
    assign w_sel_we = w_sel ? bus.we1 : bus.we0;

    assign bus.mem_addr = w_sel ? bus.addr1  : bus.addr0;
    assign bus.mem_data = w_sel ? bus.wdata1 : bus.wdata0;
    // Gated with reset explicitly so no write can slip through on a reset edge
    assign bus.mem_we   = w_accept & w_sel_we & ~reset;

    assign w_rd_accept = w_accept & ~w_sel_we;

    // Track the single outstanding read and which port it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= PORT_FETCH;
        end else begin
            r_rd_pend <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_owner <= w_sel;
            end
        end
    end

    // Response valid the cycle after a read accept; suppressed during reset
    // so a read in flight when reset arrives is never reported.
    assign w_rvalid0 = r_rd_pend & (r_rd_owner == PORT_FETCH) & ~reset;
    assign w_rvalid1 = r_rd_pend & (r_rd_owner == PORT_DATA)  & ~reset;

    assign bus.rvalid0 = w_rvalid0;
    assign bus.rvalid1 = w_rvalid1;

    // Capture the returned word so rdata keeps its value between responses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            if (w_rvalid0) begin
                r_hold0 <= bus.mem_q;
            end
            if (w_rvalid1) begin
                r_hold1 <= bus.mem_q;
            end
        end
    end

    // Memory output passes straight through in the response cycle
    assign bus.rdata0 = w_rvalid0 ? bus.mem_q : r_hold0;
    assign bus.rdata1 = w_rvalid1 ? bus.mem_q : r_hold1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A behavioural memory
//                sits on the memory bus; a transaction-level reference model
//                predicts grants, memory drive and read responses each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory with registered read
    logic [15:0] tb_mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= tb_mem[bus.mem_addr];
    end

    // Reference model state: memory image, last winner, pending response
    logic [15:0] m_mem [0:1023];
    logic        m_last;
    logic        m_pend;
    logic        m_owner;
    logic [15:0] m_rd;
    logic [15:0] m_hold0;
    logic [15:0] m_hold1;

    // Values observed at the most recent sampling point, and model grants
    logic        s_g0, s_g1, s_we, s_rv0, s_rv1;
    logic [15:0] s_rd0, s_rd1;
    logic        e_g0, e_g1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic r0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [9:0] a1, input logic [15:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    // One clock cycle: predict, compare at the falling edge, advance the model
    // through the rising edge, then return just after that edge.
    task automatic step();
        logic        eg0, eg1, ewe, ev0, ev1, n, wr;
        logic [9:0]  ea;
        logic [15:0] ed;
        @(negedge clk);
        if (reset) begin
            eg0 = 1'b0; eg1 = 1'b0;
        end else if (bus.req0 && bus.req1) begin
            eg0 = (m_last == 1'b1); eg1 = ~eg0;
        end else begin
            eg0 = bus.req0; eg1 = bus.req1;
        end
        n   = eg1;
        ea  = n ? bus.addr1  : bus.addr0;
        ed  = n ? bus.wdata1 : bus.wdata0;
        wr  = n ? bus.we1    : bus.we0;
        ewe = (eg0 | eg1) & wr;
        ev0 = !reset && m_pend && (m_owner == 1'b0);
        ev1 = !reset && m_pend && (m_owner == 1'b1);

        s_g0 = bus.gnt0; s_g1 = bus.gnt1; s_we = bus.mem_we;
        s_rv0 = bus.rvalid0; s_rv1 = bus.rvalid1;
        s_rd0 = bus.rdata0; s_rd1 = bus.rdata1;

        check_eq("gnt0", 32'(s_g0), 32'(eg0));
        check_eq("gnt1", 32'(s_g1), 32'(eg1));
        check_eq("mem_we", 32'(s_we), 32'(ewe));
        check_eq("mem_addr", 32'(bus.mem_addr), 32'(ea));
        check_eq("mem_data", 32'(bus.mem_data), 32'(ed));
        check_eq("rvalid0", 32'(s_rv0), 32'(ev0));
        check_eq("rvalid1", 32'(s_rv1), 32'(ev1));
        check_eq("rdata0", 32'(s_rd0), 32'(ev0 ? m_rd : m_hold0));
        check_eq("rdata1", 32'(s_rd1), 32'(ev1 ? m_rd : m_hold1));

        if (reset) begin
            m_last = 1'b1; m_pend = 1'b0; m_hold0 = '0; m_hold1 = '0;
        end else begin
            if (ev0) m_hold0 = m_rd;
            if (ev1) m_hold1 = m_rd;
            m_pend = 1'b0;
            if (eg0 | eg1) begin
                m_last = n;
                if (wr) begin
                    m_mem[ea] = ed;
                end else begin
                    m_pend = 1'b1; m_owner = n; m_rd = m_mem[ea];
                end
            end
        end
        e_g0 = eg0; e_g1 = eg1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        step();
        reset = 1'b0;
    endtask

    logic        p_req  [2];
    logic        p_we   [2];
    logic [9:0]  p_addr [2];
    logic [15:0] p_data [2];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] v;
            v = 16'(i * 257) ^ 16'h5a5a;
            if (i == 0) v = 16'h1234;
            if (i == 1) v = 16'h1337;
            if (i == 2) v = 16'hdead;
            if (i == 3) v = 16'hbeef;
            tb_mem[i] = v;
            m_mem[i]  = v;
        end
        m_last = 1'b1; m_pend = 1'b0; m_owner = 1'b0; m_rd = '0;
        m_hold0 = '0; m_hold1 = '0;
        reset = 1'b1;
        drv(0, 0, '0, '0, 0, 0, '0, '0);
        @(posedge clk);
        #1;
        do_reset();

        // Single fetch read at 0x000
        drv(1, 0, 10'h000, '0, 0, 0, '0, '0);
        step();
        check_eq("t1_gnt0", 32'(s_g0), 32'd1);
        drv(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        check_eq("t1_rvalid0", 32'(s_rv0), 32'd1);
        check_eq("t1_rdata0", 32'(s_rd0), 32'h1234);
        check_eq("t1_rvalid1", 32'(s_rv1), 32'd0);

        // Sustained contention alternates 0,1,0,1
        do_reset();
        drv(1, 0, 10'h001, '0, 1, 0, 10'h002, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t2_gnt1_seq", 32'(s_g1), 32'(i % 2));
            if (i > 0) check_eq("t2_rdata", 32'((i % 2 == 1) ? s_rd0 : s_rd1),
                                32'((i % 2 == 1) ? 16'h1337 : 16'hdead));
        end
        drv(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        check_eq("t2_last_rvalid1", 32'(s_rv1), 32'd1);

        // Data-port write then read-back
        drv(0, 0, '0, '0, 1, 1, 10'h003, 16'h1111);
        step();
        check_eq("t3_we_write", 32'(s_we), 32'd1);
        drv(0, 0, '0, '0, 1, 0, 10'h003, '0);
        step();
        check_eq("t3_we_read", 32'(s_we), 32'd0);
        check_eq("t3_no_rvalid_wr", 32'(s_rv1), 32'd0);
        drv(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        check_eq("t3_rdata1", 32'(s_rd1), 32'h1111);

        // Read/write collision right after reset: fetch first
        do_reset();
        drv(1, 0, 10'h000, '0, 1, 1, 10'h000, 16'haaaa);
        step();
        check_eq("t4_gnt0_first", 32'(s_g0), 32'd1);
        drv(0, 0, '0, '0, 1, 1, 10'h000, 16'haaaa);
        step();
        check_eq("t4_gnt1_next", 32'(s_g1), 32'd1);
        check_eq("t4_rdata0", 32'(s_rd0), 32'h1234);
        drv(0, 0, '0, '0, 0, 0, '0, '0);
        step();

        // Reset the cycle after a read accept: response dropped
        drv(1, 0, 10'h002, '0, 0, 0, '0, '0);
        step();
        reset = 1'b1;
        drv(1, 0, 10'h001, '0, 1, 0, 10'h002, '0);
        step();
        check_eq("t5_rv0_in_reset", 32'(s_rv0), 32'd0);
        step();
        check_eq("t5_gnt_in_reset", 32'({s_g1, s_g0}), 32'd0);
        reset = 1'b0;
        step();
        check_eq("t5_tie_to_0", 32'(s_g0), 32'd1);
        drv(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        step();

        // Idle
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t6_idle", 32'({s_we, s_g0, s_g1, s_rv0, s_rv1}), 32'd0);
        end

        // Randomised traffic with occasional reset
        for (int p = 0; p < 2; p++) p_req[p] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (p_req[p] && ((p == 0) ? e_g0 : e_g1)) p_req[p] = 1'b0;
                if (!p_req[p] && $urandom_range(0, 3) != 0) begin
                    p_req[p]  = 1'b1;
                    p_we[p]   = ($urandom_range(0, 2) == 0);
                    p_addr[p] = 10'($urandom_range(0, 15));
                    p_data[p] = 16'($urandom);
                end
            end
            reset = ($urandom_range(0, 63) == 0);
            drv(p_req[0], p_we[0], p_addr[0], p_data[0],
                p_req[1], p_we[1], p_addr[1], p_data[1]);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single-port synchronous memory (16-bit data, 10-bit address, registered read) of the accumulator datapath.
- Requester 0 is instruction fetch; requester 1 is data load/store.
- Each requester uses a req/gnt/rvalid handshake.
- The block sits between the control unit and the memory instance and drives the memory's data, addr and we inputs.
- Arbitration is round-robin, so neither requester can starve the other.

Parameters:
DATA_WIDTH, 16, memory word width
ADDR_WIDTH, 10, memory address width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 access request
we0  input  1  requester 0 write enable (1 = write, 0 = read)
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
gnt0  output  1  requester 0 granted this cycle
rvalid0  output  1  requester 0 read data valid
rdata0  output  DATA_WIDTH  requester 0 read data
req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same as port 0, for requester 1
mem_addr  output  ADDR_WIDTH  to memory addr
mem_data  output  DATA_WIDTH  to memory data
mem_we  output  1  to memory we
mem_q  input  DATA_WIDTH  from memory q

Behaviour:
- Single clock, clk. Reset is synchronous and active-high; all state changes on the rising edge of clk.
- State: last-grant pointer `last` (1 bit); response register `rd_pend` (1 bit); response owner `rd_owner` (1 bit).
- Arbitration is combinational within the cycle:
  - Only req0 asserted -> gnt0.
  - Only req1 asserted -> gnt1.
  - Both asserted -> grant the port that is not `last`.
  - At most one gnt is ever high.
- A transfer is accepted at the rising edge where reqN & gntN = 1. On that edge, `last` <= N.
- Memory drive:
  - mem_addr and mem_data are muxed from the granted port.
  - mem_we = weN & gntN.
  - With no grant: mem_we = 0, mem_addr and mem_data hold port 0 values (don't-care, but must be deterministic).
- Requester obligations:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - May deassert req in the cycle after acceptance, or keep it high for back-to-back requests.
- Read latency is 1 cycle:
  - On an accepted read, rd_pend <= 1 and rd_owner <= N.
  - In the following cycle: rvalidN = rd_pend & (rd_owner == N), and rdataN = mem_q.
  - When rvalidN = 0, rdataN holds its last value.
- Writes produce no rvalid.
- Back-to-back accepts are allowed every cycle. A new read may be accepted in the same cycle an older read's rvalid is high.
- Reset values:
  - gnt0 = gnt1 = 0 while reset is high.
  - rvalid0 = rvalid1 = 0 and mem_we = 0.
  - `last` = 1, so port 0 wins the first tie.
  - rd_pend = 0; rdata0 = rdata1 = 0.
- Reset mid-operation: an in-flight read is dropped and no rvalid is issued after reset. Any write accepted on the same edge that reset is sampled is suppressed (mem_we is gated by ~reset).
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1. Worst-case wait is 1 cycle.
- Address wrap: none at this level. Addresses pass through unmodified at full ADDR_WIDTH.

Decomposition:
- Shared package holds:
  - constants PORT_FETCH = 0 and PORT_DATA = 1;
  - the default widths DATA_WIDTH = 16 and ADDR_WIDTH = 10.
- One sub-module is natural: rr_arb2. It is the 2-way round-robin grant logic with the `last` pointer, with inputs req[1:0] and accept, and output gnt[1:0].
- The response tracking and muxes stay in the top module.

Test Plan:
- Reset, then req0 read addr 0x000 with memory preloaded 0x1234/0x1337/0xdead/0xbeef at 0..3 -> gnt0 in the same cycle; next cycle rvalid0 = 1 and rdata0 = 0x1234; rvalid1 = 0.
- req0 addr 0x001 and req1 addr 0x002 asserted together and held for 4 cycles -> grants 0,1,0,1. rvalid0 returns 0x1337, rvalid1 returns 0xdead, each one cycle after its grant.
- req1 write addr 0x003 data 0x1111, then req1 read addr 0x003 -> mem_we = 1 only in the write cycle; read returns rdata1 = 0x1111 and no rvalid on the write.
- Simultaneous req0 read 0x000 and req1 write 0x000 data 0xaaaa, immediately after reset -> port 0 is granted first and reads 0x1234; the port 1 write follows in the next cycle.
- reset asserted the cycle after a read accept at 0x002 -> no rvalid in any later cycle, gnt = 0 while reset is high, and the first tie after reset goes to port 0.
- Idle with no requests for 5 cycles -> mem_we = 0, gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0 throughout.
